// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle between the hardwired control sequencer and the datapath.
// The master modport is the sequencer. It consumes run/ir and drives the strobes.
// The slave modport is the datapath side, which drives run/ir and consumes the strobes.
interface control_sequencer_if;
    logic        run;
    logic [31:0] ir;
    logic        PCout, MARin, incPC, Zin, read, MDRin, MDRout, IRin, Yin, PCin;
    logic        ZLowOut, ZHighOut, LOin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  opcode;
    logic        instr_done;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;

    modport master (
        input  run, ir,
        output PCout, MARin, incPC, Zin, read, MDRin, MDRout, IRin, Yin, PCin,
               ZLowOut, ZHighOut, LOin, HIin, Rin, Rout, opcode,
               instr_done, halted, illegal, instr_count
    );

    modport slave (
        output run, ir,
        input  PCout, MARin, incPC, Zin, read, MDRin, MDRout, IRin, Yin, PCin,
               ZLowOut, ZHighOut, LOin, HIin, Rin, Rout, opcode,
               instr_done, halted, illegal, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0-T6 control unit for the datapath.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an illegal opcode
// halts the sequencer and sets the sticky illegal flag. When it is undefined, an
// illegal opcode executes as a NOP.
//
// state   | meaning
// IDLE    | waiting for run
// T0      | PC -> MAR, PC+1 -> Z
// T1      | Z -> PC, memory read into MDR
// T2      | MDR -> IR
// T3..T6  | execute steps, decoded from ir[31:27]
// HALTED  | stopped by HALT or an illegal trap; left only through clear
module control_sequencer (
    input logic                 clock,
    input logic                 clear,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_count;
    logic [4:0]  w_op;
    logic [3:0]  w_ra, w_rb, w_rc;
    logic        w_alu3, w_muldiv, w_unary, w_halt, w_nop, w_bad, w_trap;
    logic        w_done;
    logic        w_unused_ir;

    assign w_op = bus.ir[31:27];
    assign w_ra = bus.ir[26:23];
    assign w_rb = bus.ir[22:19];
    assign w_rc = bus.ir[18:15];

    assign w_alu3   = (w_op <= 5'd10);
    assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_unary  = (w_op == 5'd17) || (w_op == 5'd18);
    assign w_nop    = (w_op == 5'd26);
    assign w_halt   = (w_op == 5'd27);
    assign w_bad    = !(w_alu3 || w_muldiv || w_unary || w_nop || w_halt);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign w_trap      = w_bad;
    assign bus.illegal = r_illegal;
    assign w_unused_ir = &{1'b0, bus.ir[14:0]};
`else
    assign w_trap      = 1'b0;
    assign bus.illegal = 1'b0;
    assign w_unused_ir = &{1'b0, bus.ir[14:0], w_bad};
`endif

    assign bus.halted      = (r_state == S_HALTED);
    assign bus.instr_count = r_count;
    assign bus.instr_done  = w_done;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        onehot = 16'h0001 << idx;
    endfunction

    // State register; clear aborts any instruction in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Completed-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)      r_count <= 16'h0000;
        else if (w_done) r_count <= r_count + 16'h0001;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)                r_illegal <= 1'b0;
        else if (w_done && w_bad)  r_illegal <= 1'b1;
    end
`endif

    // Next-state and strobe decode from state and ir. run only affects the next state.
    always_comb begin
        w_next       = r_state;
        w_done       = 1'b0;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.incPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.ZLowOut  = 1'b0;
        bus.ZHighOut = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.Rin      = 16'h0000;
        bus.Rout     = 16'h0000;
        bus.opcode   = 5'd0;
        case (r_state)
            S_IDLE: if (bus.run) w_next = S_T0;
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.incPC = 1'b1; bus.Zin = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                bus.ZLowOut = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1;
                w_next = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                if (w_alu3) begin
                    bus.Rout = onehot(w_rb); bus.Yin = 1'b1; w_next = S_T4;
                end else if (w_muldiv) begin
                    bus.Rout = onehot(w_ra); bus.Yin = 1'b1; w_next = S_T4;
                end else if (w_unary) begin
                    bus.Rout = onehot(w_rb); bus.opcode = w_op; bus.Zin = 1'b1;
                    w_next = S_T4;
                end else begin
                    w_done = 1'b1;
                end
            end
            S_T4: begin
                if (w_alu3) begin
                    bus.Rout = onehot(w_rc); bus.opcode = w_op; bus.Zin = 1'b1;
                    w_next = S_T5;
                end else if (w_muldiv) begin
                    bus.Rout = onehot(w_rb); bus.opcode = w_op; bus.Zin = 1'b1;
                    w_next = S_T5;
                end else begin
                    bus.ZLowOut = 1'b1; bus.Rin = onehot(w_ra); w_done = 1'b1;
                end
            end
            S_T5: begin
                if (w_muldiv) begin
                    bus.ZLowOut = 1'b1; bus.LOin = 1'b1; w_next = S_T6;
                end else begin
                    bus.ZLowOut = 1'b1; bus.Rin = onehot(w_ra); w_done = 1'b1;
                end
            end
            S_T6: begin
                bus.ZHighOut = 1'b1; bus.HIin = 1'b1; w_done = 1'b1;
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
        // A final step either stops the sequencer or chains straight into the next fetch.
        if (w_done) begin
            if (w_halt || w_trap) w_next = S_HALTED;
            else if (bus.run)     w_next = S_T0;
            else                  w_next = S_IDLE;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer.
module tb_control_sequencer;
    logic clock;
    logic clear;
    int   n_checks;
    int   n_fail;

    control_sequencer_if ifc ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (ifc.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Strobe bit order: PCout MARin incPC Zin read MDRin MDRout IRin Yin PCin ZLowOut ZHighOut LOin HIin
    localparam logic [13:0] ST_NONE = 14'b00000000000000;
    localparam logic [13:0] ST_T0   = 14'b11110000000000;
    localparam logic [13:0] ST_T1   = 14'b00001100011000;
    localparam logic [13:0] ST_T2   = 14'b00000011000000;
    localparam logic [13:0] ST_Y    = 14'b00000000100000;
    localparam logic [13:0] ST_Z    = 14'b00010000000000;
    localparam logic [13:0] ST_ZLO  = 14'b00000000001000;
    localparam logic [13:0] ST_LO   = 14'b00000000001010;
    localparam logic [13:0] ST_HI   = 14'b00000000000101;

    function automatic logic [13:0] strobes();
        strobes = {ifc.PCout, ifc.MARin, ifc.incPC, ifc.Zin, ifc.read, ifc.MDRin,
                   ifc.MDRout, ifc.IRin, ifc.Yin, ifc.PCin, ifc.ZLowOut, ifc.ZHighOut,
                   ifc.LOin, ifc.HIin};
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        mk = {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        clear = 1'b0; ifc.run = 1'b0; ifc.ir = 32'h0;
        step(); step();
        n_checks++;
        if ({strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done, ifc.halted, ifc.illegal, ifc.instr_count}
            !== {14'd0, 16'd0, 16'd0, 5'd0, 3'b000, 16'd0}) begin
            n_fail++;
            $display("FAIL reset: strobes=%b Rin=%h Rout=%h op=%h done=%b halted=%b illegal=%b count=%h, required all zero",
                     strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done, ifc.halted, ifc.illegal, ifc.instr_count);
        end
        clear = 1'b1;
        step();
    endtask

    task automatic test_muldiv();
        logic [13:0] es[7]   = '{ST_T0, ST_T1, ST_T2, ST_Y, ST_Z, ST_LO, ST_HI};
        logic [15:0] erout[7] = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0040, 16'h0, 16'h0};
        logic [4:0]  eop[7]   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b10000, 5'd0, 5'd0};
        ifc.run = 1'b1; ifc.ir = mk(5'b10000, 4'd2, 4'd6, 4'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if ({strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done}
                !== {es[i], 16'h0, erout[i], eop[i], (i == 6)}) begin
                n_fail++;
                $display("FAIL mul_step%0d: got str=%b Rin=%h Rout=%h op=%h done=%b, want str=%b Rin=0000 Rout=%h op=%h done=%b",
                         i, strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done,
                         es[i], erout[i], eop[i], (i == 6));
            end
        end
        ifc.run = 1'b0;
        step();
        n_checks++;
        if ({strobes(), ifc.Rout, ifc.instr_done, ifc.instr_count} !== {ST_NONE, 16'h0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL mul_idle: str=%b Rout=%h done=%b count=%h, want zeros and count=0001",
                     strobes(), ifc.Rout, ifc.instr_done, ifc.instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] es[12]   = '{ST_T0, ST_T1, ST_T2, ST_Y, ST_Z, ST_ZLO,
                                  ST_T0, ST_T1, ST_T2, ST_Y, ST_Z, ST_ZLO};
        logic [15:0] erin[12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0010,
                                  16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002};
        logic [15:0] erout[12] = '{16'h0, 16'h0, 16'h0, 16'h0008, 16'h0080, 16'h0,
                                   16'h0, 16'h0, 16'h0, 16'h0004, 16'h0008, 16'h0};
        logic [4:0]  eop[12]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                  5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0};
        ifc.run = 1'b1; ifc.ir = mk(5'b00000, 4'd4, 4'd3, 4'd7);
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done}
                !== {es[i], erin[i], erout[i], eop[i], (i == 5 || i == 11)}) begin
                n_fail++;
                $display("FAIL alu_step%0d: got str=%b Rin=%h Rout=%h op=%h done=%b, want str=%b Rin=%h Rout=%h op=%h done=%b",
                         i, strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done,
                         es[i], erin[i], erout[i], eop[i], (i == 5 || i == 11));
            end
            if (i == 6) ifc.ir = mk(5'b00001, 4'd1, 4'd2, 4'd3);
            if (i == 10) ifc.run = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_count}
                !== {ST_NONE, 16'h0, 16'h0, 5'd0, 16'd3}) begin
                n_fail++;
                $display("FAIL alu_idle%0d: str=%b Rin=%h Rout=%h op=%h count=%h, want zeros and count=0003",
                         i, strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_count);
            end
        end
    endtask

    task automatic test_unary();
        logic [13:0] es[5]    = '{ST_T0, ST_T1, ST_T2, ST_Z, ST_ZLO};
        logic [15:0] erin[5]  = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0020};
        logic [15:0] erout[5] = '{16'h0, 16'h0, 16'h0, 16'h0200, 16'h0};
        logic [4:0]  eop[5]   = '{5'd0, 5'd0, 5'd0, 5'b10001, 5'd0};
        ifc.run = 1'b1; ifc.ir = mk(5'b10001, 4'd5, 4'd9, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done}
                !== {es[i], erin[i], erout[i], eop[i], (i == 4)}) begin
                n_fail++;
                $display("FAIL neg_step%0d: got str=%b Rin=%h Rout=%h op=%h done=%b, want str=%b Rin=%h Rout=%h op=%h done=%b",
                         i, strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done,
                         es[i], erin[i], erout[i], eop[i], (i == 4));
            end
        end
        ifc.run = 1'b0;
        step();
        n_checks++;
        if ({strobes(), ifc.instr_count} !== {ST_NONE, 16'd4}) begin
            n_fail++;
            $display("FAIL neg_idle: str=%b count=%h, want zeros and count=0004", strobes(), ifc.instr_count);
        end
    endtask

    task automatic test_nop_illegal();
        logic [13:0] es[8] = '{ST_T0, ST_T1, ST_T2, ST_NONE, ST_T0, ST_T1, ST_T2, ST_NONE};
        ifc.run = 1'b1; ifc.ir = mk(5'b11010, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({strobes(), ifc.Rin, ifc.Rout, ifc.instr_done, ifc.halted}
                !== {es[i], 16'h0, 16'h0, (i == 3 || i == 7), 1'b0}) begin
                n_fail++;
                $display("FAIL nopill_step%0d: got str=%b Rin=%h Rout=%h done=%b halted=%b, want str=%b done=%b",
                         i, strobes(), ifc.Rin, ifc.Rout, ifc.instr_done, ifc.halted, es[i], (i == 3 || i == 7));
            end
            if (i == 4) ifc.ir = mk(5'b11111, 4'd0, 4'd0, 4'd0);
        end
        step();
        n_checks++;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if ({strobes(), ifc.halted, ifc.illegal, ifc.instr_count} !== {ST_NONE, 1'b1, 1'b1, 16'd6}) begin
            n_fail++;
            $display("FAIL illegal_trap: str=%b halted=%b illegal=%b count=%h, want zeros halted=1 illegal=1 count=0006",
                     strobes(), ifc.halted, ifc.illegal, ifc.instr_count);
        end
`else
        if ({strobes(), ifc.halted, ifc.illegal, ifc.instr_count} !== {ST_T0, 1'b0, 1'b0, 16'd6}) begin
            n_fail++;
            $display("FAIL illegal_nop: str=%b halted=%b illegal=%b count=%h, want T0 halted=0 illegal=0 count=0006",
                     strobes(), ifc.halted, ifc.illegal, ifc.instr_count);
        end
`endif
        ifc.run = 1'b0;
        clear = 1'b0;
        #1;
        clear = 1'b1;
        step();
    endtask

    task automatic test_halt();
        int bad;
        ifc.run = 1'b1; ifc.ir = mk(5'b11011, 4'd0, 4'd0, 4'd0);
        step(); step(); step(); step();
        n_checks++;
        if ({ifc.instr_done, ifc.halted} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_t3: done=%b halted=%b, want done=1 halted=0", ifc.instr_done, ifc.halted);
        end
        step();
        n_checks++;
        if ({ifc.halted, ifc.instr_count, strobes()} !== {1'b1, 16'd1, ST_NONE}) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b count=%h str=%b, want halted=1 count=0001 str=0",
                     ifc.halted, ifc.instr_count, strobes());
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({ifc.halted, ifc.instr_done, strobes(), ifc.instr_count} !== {2'b10, ST_NONE, 16'd1}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_hold: %0d of 20 cycles left HALTED or strobed, want 0", bad);
        end
        clear = 1'b0;
        #1;
        n_checks++;
        if ({ifc.halted, ifc.instr_count} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL halt_clear: halted=%b count=%h, want halted=0 count=0000", ifc.halted, ifc.instr_count);
        end
        ifc.run = 1'b0;
        clear = 1'b1;
        step();
        n_checks++;
        if ({ifc.halted, strobes()} !== {1'b0, ST_NONE}) begin
            n_fail++;
            $display("FAIL halt_idle: halted=%b str=%b, want idle", ifc.halted, strobes());
        end
    endtask

    task automatic test_wrap_clear();
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        #1;
        n_checks++;
        if (ifc.instr_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: count=%h, want ffff", ifc.instr_count);
        end
        ifc.run = 1'b1; ifc.ir = mk(5'b11010, 4'd0, 4'd0, 4'd0);
        step(); step(); step(); step();
        step();
        n_checks++;
        if ({ifc.instr_count, strobes()} !== {16'h0000, ST_T0}) begin
            n_fail++;
            $display("FAIL wrap: count=%h str=%b, want count=0000 str=T0", ifc.instr_count, strobes());
        end
        step();
        n_checks++;
        if (strobes() !== ST_T1) begin
            n_fail++;
            $display("FAIL clear_pre_t1: str=%b, want %b", strobes(), ST_T1);
        end
        clear = 1'b0;
        #1;
        n_checks++;
        if ({strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done, ifc.halted, ifc.illegal, ifc.instr_count}
            !== {14'd0, 16'd0, 16'd0, 5'd0, 3'b000, 16'd0}) begin
            n_fail++;
            $display("FAIL clear_async: str=%b Rin=%h Rout=%h op=%h done=%b count=%h, want all zero",
                     strobes(), ifc.Rin, ifc.Rout, ifc.opcode, ifc.instr_done, ifc.instr_count);
        end
        ifc.run = 1'b0;
        clear = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear    = 1'b0;
        ifc.run  = 1'b0;
        ifc.ir   = 32'h0;
        @(negedge clock);
        test_reset();
        test_muldiv();
        test_back_to_back();
        test_unary();
        test_nop_illegal();
        test_halt();
        test_wrap_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
